// File: rtl/ysyx_24080006_axi_sram_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_axi
// Purpose  : Single-beat AXI4 bundle shared by the LSU/IFU master port and
//            the on-chip SRAM responder. It carries only the members that
//            single-beat traffic needs.
// Modports : slave  - responder side (drives readys, R and B channels)
//            master - requester side (drives AR, AW, W, rready, bready)
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_24080006_axi;
    // Read address / read data
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    // Write address / write data / write response
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport slave (
        input  arvalid, araddr, arid, rready,
        input  awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, rid, rlast,
        output awready, wready, bvalid, bresp, bid
    );

    modport master (
        output arvalid, araddr, arid, rready,
        output awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, rid, rlast,
        input  awready, wready, bvalid, bresp, bid
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_24080006_axi_sram.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24080006_axi_sram
// Purpose  : Single-beat AXI4 responder backed by a 32-bit word SRAM.
//            Independent read and write FSMs, each with a fixed response
//            latency; byte-lane writes via wstrb; DECERR outside the window.
// Ports    : clock  - system clock, all logic on the rising edge
//            reset  - synchronous, active-low
//            axi_s  - AXI slave modport (AR/R/AW/W/B, single beat)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24080006_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h0f00_0000,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    ysyx_24080006_axi.slave         axi_s
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END    = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
    // Counter preload; only meaningful when the latency is non-zero.
    localparam logic [3:0]  RD_CNT_INIT = 4'(RD_LAT - 1);
    localparam logic [3:0]  WR_CNT_INIT = 4'(WR_LAT - 1);

    typedef enum logic [1:0] { R_IDLE = 2'd0, R_LAT = 2'd1, R_RESP = 2'd2 } r_state_t;
    typedef enum logic [1:0] { W_IDLE = 2'd0, W_LAT = 2'd1, W_RESP = 2'd2 } w_state_t;

    // 33-bit compare so the window can never wrap around 2^32.
    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, ADDR_BASE}) && ({1'b0, a} < ADDR_END);
    endfunction

    // Byte offset bits [1:0] are dropped: the full aligned word is addressed.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------------------------------------------------------- read
    r_state_t    rstate_q;
    logic [3:0]  rcnt_q;
    logic [31:0] araddr_q;
    logic [3:0]  arid_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [3:0]  rid_q;
    logic        rlast_q;

    // With zero latency the response is loaded in the AR handshake cycle, so
    // the live request is used there and the captured one afterwards.
    logic [31:0] rd_addr;
    logic [3:0]  rd_id;
    logic        rd_ok;
    assign rd_addr = (rstate_q == R_IDLE) ? axi_s.araddr : araddr_q;
    assign rd_id   = (rstate_q == R_IDLE) ? axi_s.arid   : arid_q;
    assign rd_ok   = in_range(rd_addr);

    always_ff @(posedge clock) begin
        if (!reset) begin
            rstate_q  <= R_IDLE;
            rcnt_q    <= 4'd0;
            araddr_q  <= 32'd0;
            arid_q    <= 4'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            rid_q     <= 4'd0;
            rlast_q   <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (axi_s.arvalid && arready_q) begin
                        araddr_q  <= axi_s.araddr;
                        arid_q    <= axi_s.arid;
                        arready_q <= 1'b0;
                        if (RD_LAT == 0) begin
                            rdata_q  <= rd_ok ? mem[word_idx(rd_addr)] : 32'd0;
                            rresp_q  <= rd_ok ? 2'b00 : 2'b11;
                            rid_q    <= rd_id;
                            rlast_q  <= 1'b1;
                            rvalid_q <= 1'b1;
                            rstate_q <= R_RESP;
                        end else begin
                            rcnt_q   <= RD_CNT_INIT;
                            rstate_q <= R_LAT;
                        end
                    end else begin
                        // Also provides the one-cycle ready delay after reset.
                        arready_q <= 1'b1;
                    end
                end
                R_LAT: begin
                    if (rcnt_q == 4'd0) begin
                        rdata_q  <= rd_ok ? mem[word_idx(rd_addr)] : 32'd0;
                        rresp_q  <= rd_ok ? 2'b00 : 2'b11;
                        rid_q    <= rd_id;
                        rlast_q  <= 1'b1;
                        rvalid_q <= 1'b1;
                        rstate_q <= R_RESP;
                    end else begin
                        rcnt_q <= rcnt_q - 4'd1;
                    end
                end
                R_RESP: begin
                    if (axi_s.rready) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- write
    w_state_t    wstate_q;
    logic [3:0]  wcnt_q;
    logic [31:0] awaddr_q;
    logic [3:0]  awid_q;
    logic        aw_have_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        w_have_q;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic [3:0]  bid_q;

    logic        aw_hs;
    logic        w_hs;
    logic        wr_both;
    logic [31:0] wr_addr;
    logic [3:0]  wr_id;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_ok;
    logic [1:0]  wr_resp;
    logic        wr_commit;

    assign aw_hs   = axi_s.awvalid && awready_q;
    assign w_hs    = axi_s.wvalid  && wready_q;
    // Both halves of the request are present once each was captured earlier
    // or is being handshaken now; AW and W may arrive in either order.
    assign wr_both = (aw_have_q || aw_hs) && (w_have_q || w_hs);
    assign wr_addr = aw_hs ? axi_s.awaddr : awaddr_q;
    assign wr_id   = aw_hs ? axi_s.awid   : awid_q;
    assign wr_data = w_hs  ? axi_s.wdata  : wdata_q;
    assign wr_strb = w_hs  ? axi_s.wstrb  : wstrb_q;
    assign wr_ok   = in_range(wr_addr);
    assign wr_resp = wr_ok ? 2'b00 : 2'b11;
    // A reset in the commit cycle drops the write along with its response.
    assign wr_commit = reset &&
                       (((wstate_q == W_IDLE) && wr_both && (WR_LAT == 0)) ||
                        ((wstate_q == W_LAT)  && (wcnt_q == 4'd0)));

    // Storage is never cleared by reset.
    always_ff @(posedge clock) begin
        if (wr_commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wstate_q  <= W_IDLE;
            wcnt_q    <= 4'd0;
            awaddr_q  <= 32'd0;
            awid_q    <= 4'd0;
            aw_have_q <= 1'b0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            w_have_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= 4'd0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q  <= axi_s.awaddr;
                        awid_q    <= axi_s.awid;
                        aw_have_q <= 1'b1;
                        awready_q <= 1'b0;
                    end else if (!aw_have_q) begin
                        awready_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q  <= axi_s.wdata;
                        wstrb_q  <= axi_s.wstrb;
                        w_have_q <= 1'b1;
                        wready_q <= 1'b0;
                    end else if (!w_have_q) begin
                        wready_q <= 1'b1;
                    end
                    if (wr_both) begin
                        aw_have_q <= 1'b0;
                        w_have_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (WR_LAT == 0) begin
                            bvalid_q <= 1'b1;
                            bid_q    <= wr_id;
                            bresp_q  <= wr_resp;
                            wstate_q <= W_RESP;
                        end else begin
                            wcnt_q   <= WR_CNT_INIT;
                            wstate_q <= W_LAT;
                        end
                    end
                end
                W_LAT: begin
                    if (wcnt_q == 4'd0) begin
                        bvalid_q <= 1'b1;
                        bid_q    <= wr_id;
                        bresp_q  <= wr_resp;
                        wstate_q <= W_RESP;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                W_RESP: begin
                    if (axi_s.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // All outputs come straight from registers.
    assign axi_s.arready = arready_q;
    assign axi_s.rvalid  = rvalid_q;
    assign axi_s.rdata   = rdata_q;
    assign axi_s.rresp   = rresp_q;
    assign axi_s.rid     = rid_q;
    assign axi_s.rlast   = rlast_q;
    assign axi_s.awready = awready_q;
    assign axi_s.wready  = wready_q;
    assign axi_s.bvalid  = bvalid_q;
    assign axi_s.bresp   = bresp_q;
    assign axi_s.bid     = bid_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_axi_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24080006_axi_sram
// Purpose  : Self-checking bench for the AXI SRAM responder. A vector table
//            drives single-beat reads/writes; expected responses go into
//            scoreboard queues when a request is issued and are popped when
//            the response appears. Hand-written sequences cover reset,
//            W-before-AW ordering and back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24080006_axi_sram;

    localparam logic [31:0] BASE   = 32'h0f00_0000;
    localparam int          DEPTH  = 2048;
    localparam int          RD_LAT = 2;
    localparam int          WR_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_24080006_axi bus();

    ysyx_24080006_axi_sram #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .axi_s(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
    } resp_t;

    resp_t rq[$];
    resp_t bq[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  id;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Waits for rvalid (entered at the negedge right after the AR handshake),
    // checks latency, optional hold stability, payload, then takes the beat.
    task automatic wait_r(input int hold);
        int    n;
        int    bad;
        resp_t e;
        logic [38:0] snap;
        n = 1;
        while (!bus.rvalid && n < 40) begin
            step();
            n++;
        end
        if (!bus.rvalid) begin
            chk("r_timeout", 32'(bus.rvalid), 32'd1);
            return;
        end
        chk("r_latency", 32'(n), 32'(RD_LAT + 1));
        bad  = 0;
        snap = {bus.rvalid, bus.rdata, bus.rresp, bus.rid};
        for (int k = 0; k < hold; k++) begin
            step();
            if ({bus.rvalid, bus.rdata, bus.rresp, bus.rid} !== snap) bad++;
        end
        if (hold > 0) chk("r_hold_stable", 32'(bad), 32'd0);
        if (rq.size() == 0) begin
            chk("r_unexpected", 32'd1, 32'd0);
            return;
        end
        e = rq.pop_front();
        chk("rdata", bus.rdata, e.data);
        chk("rresp", 32'(bus.rresp), 32'(e.resp));
        chk("rid",   32'(bus.rid),   32'(e.id));
        chk("rlast", 32'(bus.rlast), 32'd1);
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        chk("r_after_hs_rvalid",  32'(bus.rvalid),  32'd0);
        chk("r_after_hs_arready", 32'(bus.arready), 32'd1);
    endtask

    task automatic wait_b(input int hold);
        int    n;
        int    bad;
        resp_t e;
        logic [6:0] snap;
        n = 1;
        while (!bus.bvalid && n < 40) begin
            step();
            n++;
        end
        if (!bus.bvalid) begin
            chk("b_timeout", 32'(bus.bvalid), 32'd1);
            return;
        end
        chk("b_latency", 32'(n), 32'(WR_LAT + 1));
        bad  = 0;
        snap = {bus.bvalid, bus.bresp, bus.bid};
        for (int k = 0; k < hold; k++) begin
            step();
            if ({bus.bvalid, bus.bresp, bus.bid} !== snap) bad++;
            if (bus.wready !== 1'b0 || bus.awready !== 1'b0) bad++;
        end
        if (hold > 0) chk("b_hold_stable", 32'(bad), 32'd0);
        if (bq.size() == 0) begin
            chk("b_unexpected", 32'd1, 32'd0);
            return;
        end
        e = bq.pop_front();
        chk("bresp", 32'(bus.bresp), 32'(e.resp));
        chk("bid",   32'(bus.bid),   32'(e.id));
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk("b_after_hs_bvalid", 32'(bus.bvalid), 32'd0);
        chk("b_after_hs_readys", 32'({bus.awready, bus.wready}), 32'd3);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int hold);
        int cyc;
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arid    = id;
        cyc = 0;
        while (!bus.arready && cyc < 20) begin
            step();
            cyc++;
        end
        if (!bus.arready) begin
            chk("ar_timeout", 32'(bus.arready), 32'd1);
            bus.arvalid = 1'b0;
            return;
        end
        step();
        bus.arvalid = 1'b0;
        wait_r(hold);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id, input int hold);
        int   cyc;
        logic aw_p;
        logic w_p;
        logic ha;
        logic hw;
        bus.awaddr = addr;
        bus.awid   = id;
        bus.wdata  = data;
        bus.wstrb  = strb;
        aw_p = 1'b1;
        w_p  = 1'b1;
        cyc  = 0;
        while ((aw_p || w_p) && cyc < 20) begin
            bus.awvalid = aw_p;
            bus.wvalid  = w_p;
            ha = aw_p && bus.awready;
            hw = w_p  && bus.wready;
            step();
            if (ha) aw_p = 1'b0;
            if (hw) w_p  = 1'b0;
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (aw_p || w_p) begin
            chk("aw_w_timeout", 32'({aw_p, w_p}), 32'd0);
            return;
        end
        wait_b(hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.rready = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0; bus.bready = 1'b0;

        //         wr    addr           data           strb   id     exp_data       resp
        vecs[0]  = '{1'b1, 32'h0f00_0010, 32'hdead_beef, 4'hf, 4'h1, 32'h0,         2'b00};
        vecs[1]  = '{1'b0, 32'h0f00_0010, 32'h0,         4'h0, 4'h3, 32'hdead_beef, 2'b00};
        vecs[2]  = '{1'b1, 32'h0f00_0010, 32'h0000_ab00, 4'h2, 4'h4, 32'h0,         2'b00};
        vecs[3]  = '{1'b0, 32'h0f00_0010, 32'h0,         4'h0, 4'h5, 32'hdead_abef, 2'b00};
        vecs[4]  = '{1'b1, 32'h0f00_1ffc, 32'h1234_5678, 4'hf, 4'h6, 32'h0,         2'b00};
        vecs[5]  = '{1'b0, 32'h0f00_1ffc, 32'h0,         4'h0, 4'h7, 32'h1234_5678, 2'b00};
        vecs[6]  = '{1'b1, 32'h0f00_0003, 32'haabb_ccdd, 4'hf, 4'h8, 32'h0,         2'b00};
        vecs[7]  = '{1'b1, 32'h0f00_0000, 32'h1122_3344, 4'h8, 4'h9, 32'h0,         2'b00};
        vecs[8]  = '{1'b1, 32'h0f00_0000, 32'h0,         4'h0, 4'ha, 32'h0,         2'b00};
        vecs[9]  = '{1'b1, 32'h0eff_fffc, 32'hffff_ffff, 4'hf, 4'hb, 32'h0,         2'b11};
        vecs[10] = '{1'b1, 32'h0f00_2000, 32'hffff_ffff, 4'hf, 4'hc, 32'h0,         2'b11};
        vecs[11] = '{1'b0, 32'h0f00_0002, 32'h0,         4'h0, 4'hd, 32'h11bb_ccdd, 2'b00};
        vecs[12] = '{1'b0, 32'h0f00_1ffc, 32'h0,         4'h0, 4'he, 32'h1234_5678, 2'b00};
        vecs[13] = '{1'b0, 32'h0f00_2000, 32'h0,         4'h0, 4'hf, 32'h0,         2'b11};
        vecs[14] = '{1'b0, 32'h0eff_fffc, 32'h0,         4'h0, 4'h0, 32'h0,         2'b11};
        vecs[15] = '{1'b0, 32'hffff_fffc, 32'h0,         4'h0, 4'h1, 32'h0,         2'b11};

        // Power-on reset
        repeat (3) step();
        chk("rst_readys",  32'({bus.arready, bus.awready, bus.wready}), 32'd0);
        chk("rst_valids",  32'({bus.rvalid, bus.bvalid, bus.rlast}), 32'd0);
        chk("rst_rdata",   bus.rdata, 32'd0);
        chk("rst_resp_id", 32'({bus.rresp, bus.bresp, bus.rid, bus.bid}), 32'd0);
        rst_n = 1'b1;
        chk("rel_readys_c1", 32'({bus.arready, bus.awready, bus.wready}), 32'd0);
        step();
        chk("rel_readys_c2", 32'({bus.arready, bus.awready, bus.wready}), 32'd7);

        // Reset held for three cycles in the middle of a read
        begin
            int hi;
            bus.arvalid = 1'b1;
            bus.araddr  = 32'h0f00_0010;
            bus.arid    = 4'h7;
            step();
            bus.arvalid = 1'b0;
            rst_n = 1'b0;
            repeat (3) step();
            chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
            rst_n = 1'b1;
            chk("mid_rel_arready_c1", 32'(bus.arready), 32'd0);
            step();
            chk("mid_rel_arready_c2", 32'(bus.arready), 32'd1);
            hi = 0;
            for (int k = 0; k < 10; k++) begin
                if (bus.rvalid) hi++;
                step();
            end
            chk("mid_rst_no_resp", 32'(hi), 32'd0);
        end

        // Table-driven single transactions
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                bq.push_back('{32'h0, vecs[i].exp_resp, vecs[i].id});
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].id, 0);
            end else begin
                rq.push_back('{vecs[i].exp_data, vecs[i].exp_resp, vecs[i].id});
                do_read(vecs[i].addr, vecs[i].id, 0);
            end
        end

        // W accepted three cycles before AW
        begin
            bq.push_back('{32'h0, 2'b00, 4'h2});
            bus.wvalid = 1'b1;
            bus.wdata  = 32'hcafe_f00d;
            bus.wstrb  = 4'hf;
            chk("w_first_wready", 32'(bus.wready), 32'd1);
            step();
            bus.wvalid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                chk("w_first_wready_low", 32'({bus.wready, bus.bvalid}), 32'd0);
                step();
            end
            bus.awvalid = 1'b1;
            bus.awaddr  = 32'h0f00_0020;
            bus.awid    = 4'h2;
            chk("w_first_awready", 32'(bus.awready), 32'd1);
            step();
            bus.awvalid = 1'b0;
            wait_b(2);
            rq.push_back('{32'hcafe_f00d, 2'b00, 4'h6});
            do_read(32'h0f00_0020, 4'h6, 0);
        end

        // Back-pressure: responses held ten cycles
        rq.push_back('{32'hdead_abef, 2'b00, 4'h9});
        do_read(32'h0f00_0010, 4'h9, 10);
        bq.push_back('{32'h0, 2'b00, 4'h4});
        do_write(32'h0f00_0024, 32'h0bad_f00d, 4'h5, 4'h4, 10);
        rq.push_back('{32'h00ad_000d, 2'b00, 4'h3});
        do_read(32'h0f00_0024, 4'h3, 0);

        // Exactly one beat per request after an LSU-style rready
        begin
            int extra;
            extra = 0;
            for (int k = 0; k < 4; k++) begin
                if (bus.rvalid) extra++;
                step();
            end
            chk("single_beat", 32'(extra), 32'd0);
        end

        chk("scoreboard_empty", 32'(rq.size() + bq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
